line_memory: RTL

LINE_MEMORY -- requirements
Module: line_memory

---
 rtl/line_memory.sv | 103 ++++++++++
 1 files changed

// File: rtl/line_memory.sv
// rtl/line_memory.sv - single-outstanding 256-bit line store with fixed ack latency.
module line_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [IW-1:0]   line_q, line_d;
    logic [255:0]    wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            ack_q, ack_d;
    logic [255:0]    rdata_q, rdata_d;
    logic            mem_we;

    logic [255:0]    mem_q [DEPTH];

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IW], addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    line_d  = addr_i[5 +: IW];
                    wdata_d = data_i;
                    wr_d    = write_i;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                // The edge leaving WAIT both commits the write and registers read data.
                if (cnt_q == 8'd1) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[line_q];
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem_q[line_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;
endmodule
